// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mlp_pkg
// Purpose  : FP32 types, constants and helpers shared by the MLP datapath.
// Revision : 1.0  initial release
// ============================================================================
package mlp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_QNAN     = 32'h7FC0_0000;
  localparam fp32_t FP_POS_ZERO = 32'h0000_0000;
  localparam fp32_t FP_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

  function automatic logic fp32_is_nan(input fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage : mlp_pkg
`default_nettype wire

// File: rtl/argmax_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier_if
// Purpose  : Score/start inputs and result/status outputs of the arg-max stage.
// Revision : 1.0  initial release
// ============================================================================
interface argmax_classifier_if #(
  parameter int N_CLASSES = 10
);

  localparam int IDX_W = $clog2(N_CLASSES);

  mlp_pkg::fp32_t   scores [N_CLASSES];
  logic             prev_layer_end;
  logic [IDX_W-1:0] class_idx;
  mlp_pkg::fp32_t   max_score;
  logic             all_nan;
  logic             busy;
  logic             done;

  modport master (
    output scores, prev_layer_end,
    input  class_idx, max_score, all_nan, busy, done
  );

  modport slave (
    input  scores, prev_layer_end,
    output class_idx, max_score, all_nan, busy, done
  );

endinterface : argmax_classifier_if
`default_nettype wire

// File: rtl/fp32_compare.sv
`default_nettype none
// ============================================================================
// Module   : fp32_compare
// Purpose  : Combinational IEEE-754 single comparator (a > b), NaN flags.
// Revision : 1.0  initial release
// ============================================================================
module fp32_compare
  import mlp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  a_gt_b,
  output logic  a_is_nan,
  output logic  b_is_nan
);

  fp32_t w_a_key;
  fp32_t w_b_key;
  logic  w_both_zero;

  // Map sign-magnitude onto an unsigned total order; only +0/-0 needs a fixup.
  assign w_a_key     = a[31] ? ~a : (a | FP_NEG_ZERO);
  assign w_b_key     = b[31] ? ~b : (b | FP_NEG_ZERO);
  assign w_both_zero = ((a | b) & ~FP_NEG_ZERO) == FP_POS_ZERO;

  assign a_is_nan = fp32_is_nan(a);
  assign b_is_nan = fp32_is_nan(b);
  assign a_gt_b   = !a_is_nan && !b_is_nan && !w_both_zero && (w_a_key > w_b_key);

endmodule : fp32_compare
`default_nettype wire

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier
// Purpose  : Snapshot N_CLASSES FP32 scores on start, scan one per cycle, report arg-max.
// Revision : 1.0  initial release
// ============================================================================
module argmax_classifier
  import mlp_pkg::*;
#(
  parameter int N_CLASSES = 10
) (
  input  logic CLK,
  input  logic reset,
  argmax_classifier_if.slave bus
);

  localparam int               IDX_W    = $clog2(N_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  generate
    if (N_CLASSES < 2 || N_CLASSES > 1024) begin : g_bad_n_classes
      $error("argmax_classifier: N_CLASSES must be in 2..1024");
    end
  endgenerate

  argmax_state_e    state_q, state_d;
  logic             pel_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  fp32_t            snap_q [N_CLASSES];
  fp32_t            snap_d [N_CLASSES];
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  fp32_t            best_val_q, best_val_d;
  logic             best_valid_q, best_valid_d;
  logic [IDX_W-1:0] class_idx_q, class_idx_d;
  fp32_t            max_score_q, max_score_d;
  logic             all_nan_q, all_nan_d;

  logic             w_start;
  fp32_t            w_cand;
  logic             w_cand_gt;
  logic             w_cand_nan;
  logic             w_best_nan;
  logic             w_take;
  logic             w_fin_valid;
  logic [IDX_W-1:0] w_fin_idx;
  fp32_t            w_fin_val;

  assign w_start = bus.prev_layer_end & ~pel_q;
  assign w_cand  = snap_q[idx_q];

  fp32_compare u_cmp (
    .a        (w_cand),
    .b        (best_val_q),
    .a_gt_b   (w_cand_gt),
    .a_is_nan (w_cand_nan),
    .b_is_nan (w_best_nan)
  );

  // A NaN best can only mean nothing valid has been seen yet.
  assign w_take      = !w_cand_nan && (!best_valid_q || w_best_nan || w_cand_gt);
  assign w_fin_valid = w_take | best_valid_q;
  assign w_fin_idx   = w_take ? idx_q  : best_idx_q;
  assign w_fin_val   = w_take ? w_cand : best_val_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    best_valid_d = best_valid_q;
    class_idx_d  = class_idx_q;
    max_score_d  = max_score_q;
    all_nan_d    = all_nan_q;

    if (w_start) begin
      // Start from any state, including an abort of a scan in flight.
      state_d      = ST_SCAN;
      snap_d       = bus.scores;
      best_idx_d   = '0;
      best_val_d   = bus.scores[0];
      best_valid_d = !fp32_is_nan(bus.scores[0]);
      idx_d        = IDX_W'(1);
    end else begin
      case (state_q)
        ST_SCAN: begin
          best_idx_d   = w_fin_idx;
          best_val_d   = w_fin_val;
          best_valid_d = w_fin_valid;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d     = ST_DONE;
            idx_d       = '0;
            class_idx_d = w_fin_valid ? w_fin_idx : '0;
            max_score_d = w_fin_valid ? w_fin_val : FP_QNAN;
            all_nan_d   = !w_fin_valid;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pel_q        <= 1'b0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_val_q   <= FP_POS_ZERO;
      best_valid_q <= 1'b0;
      class_idx_q  <= '0;
      max_score_q  <= FP_POS_ZERO;
      all_nan_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pel_q        <= bus.prev_layer_end;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
      best_valid_q <= best_valid_d;
      class_idx_q  <= class_idx_d;
      max_score_q  <= max_score_d;
      all_nan_q    <= all_nan_d;
    end
  end

  // Snapshot is pure datapath; it is always rewritten before it is read.
  always_ff @(posedge CLK) begin
    snap_q <= snap_d;
  end

  assign bus.class_idx = class_idx_q;
  assign bus.max_score = max_score_q;
  assign bus.all_nan   = all_nan_q;
  assign bus.busy      = (state_q == ST_SCAN);
  assign bus.done      = (state_q == ST_DONE);

endmodule : argmax_classifier
`default_nettype wire
